// File: rtl/demux_pkg.sv
// rtl/demux_pkg.sv - shared channel codes, sizes and buffer states for the demux deserializer
package demux_pkg;

    localparam int SEL_W  = 2;
    localparam int NUM_CH = 4;

    localparam logic [SEL_W-1:0] CH_A = 2'd0;
    localparam logic [SEL_W-1:0] CH_B = 2'd1;
    localparam logic [SEL_W-1:0] CH_C = 2'd2;
    localparam logic [SEL_W-1:0] CH_D = 2'd3;

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } buf_state_e;

    function automatic logic [NUM_CH-1:0] ch_onehot(input logic [SEL_W-1:0] ch);
        return NUM_CH'(1) << ch;
    endfunction

endpackage

// File: rtl/demux_deser_lane.sv
// rtl/demux_deser_lane.sv - one channel's shift register and bit counter
module demux_deser_lane #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             shift_en,
    input  logic             bit_in,
    output logic             done,
    output logic [WIDTH-1:0] word
);

    localparam int                CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0]  LAST  = CNT_W'(WIDTH - 1);

    // Only WIDTH-1 bits are stored; the final bit goes straight into the word.
    logic [WIDTH-2:0] r_shreg;
    logic [CNT_W-1:0] r_cnt;

    assign word = {r_shreg, bit_in};
    assign done = shift_en && (r_cnt == LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_shreg <= '0;
            r_cnt   <= '0;
        end else if (shift_en) begin
            r_shreg <= word[WIDTH-2:0];
            r_cnt   <= (r_cnt == LAST) ? '0 : r_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/demux_deser.sv
// rtl/demux_deser.sv - deserializes the four demux outputs into tagged words with a one-entry output buffer
module demux_deser
    import demux_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [SEL_W-1:0] sel,
    input  logic             a,
    input  logic             b,
    input  logic             c,
    input  logic             d,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [SEL_W-1:0] out_ch,
    output logic             overflow,
    output logic             route_err,
    input  logic             clr_err
);

    logic [NUM_CH-1:0] w_bits;
    logic [NUM_CH-1:0] w_sel_onehot;
    logic [NUM_CH-1:0] w_done;
    logic [WIDTH-1:0]  w_word [NUM_CH];
    logic              w_any_done;
    logic [WIDTH-1:0]  w_sel_word;
    logic              w_fault;
    logic              w_drop;

    assign w_bits       = {d, c, b, a};
    assign w_sel_onehot = ch_onehot(sel);

    for (genvar i = 0; i < NUM_CH; i++) begin : g_lane
        demux_deser_lane #(.WIDTH(WIDTH)) u_lane (
            .clk      (clk),
            .rst      (rst),
            .shift_en (in_valid && w_sel_onehot[i]),
            .bit_in   (w_bits[i]),
            .done     (w_done[i]),
            .word     (w_word[i])
        );
    end

    // Only the selected lane can shift, so its word is the only possible completion.
    assign w_any_done = |w_done;
    assign w_sel_word = w_word[sel];
    assign w_fault    = in_valid && |(w_bits & ~w_sel_onehot);

    buf_state_e r_state;
    logic             r_out_valid;
    logic [WIDTH-1:0] r_out_data;
    logic [SEL_W-1:0] r_out_ch;
    logic             r_overflow;
    logic             r_route_err;

    assign w_drop = (r_state == ST_FULL) && !out_ready && w_any_done;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_EMPTY;
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_ch    <= '0;
            r_overflow  <= 1'b0;
            r_route_err <= 1'b0;
        end else begin
            case (r_state)
                ST_EMPTY: begin
                    if (w_any_done) begin
                        r_state     <= ST_FULL;
                        r_out_valid <= 1'b1;
                        r_out_data  <= w_sel_word;
                        r_out_ch    <= sel;
                    end
                end
                ST_FULL: begin
                    if (out_ready && w_any_done) begin
                        r_out_data <= w_sel_word;
                        r_out_ch   <= sel;
                    end else if (out_ready) begin
                        r_state     <= ST_EMPTY;
                        r_out_valid <= 1'b0;
                    end
                end
                default: begin
                    r_state     <= ST_EMPTY;
                    r_out_valid <= 1'b0;
                end
            endcase
            // A fresh error in the clearing cycle keeps the flag set.
            r_overflow  <= (r_overflow  && !clr_err) || w_drop;
            r_route_err <= (r_route_err && !clr_err) || w_fault;
        end
    end

    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;
    assign out_ch    = r_out_ch;
    assign overflow  = r_overflow;
    assign route_err = r_route_err;

endmodule

// File: tb/tb_demux_deser.sv
// tb/tb_demux_deser.sv - directed scoreboard bench for demux_deser
module tb_demux_deser;
    import demux_pkg::*;

    localparam int WIDTH = 8;

    logic             clk = 1'b0;
    logic             rst;
    logic             in_valid;
    logic [SEL_W-1:0] sel;
    logic             a, b, c, d;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;
    logic [SEL_W-1:0] out_ch;
    logic             overflow;
    logic             route_err;
    logic             clr_err;

    int n_tests = 0;
    int n_fail  = 0;
    int n_popped = 0;
    logic [SEL_W+WIDTH-1:0] exp_q[$];

    always #5 clk = ~clk;

    demux_deser #(.WIDTH(WIDTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .sel       (sel),
        .a         (a),
        .b         (b),
        .c         (c),
        .d         (d),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_ch    (out_ch),
        .overflow  (overflow),
        .route_err (route_err),
        .clr_err   (clr_err)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Inputs change only #1 after posedge, so a handshake seen at negedge happens at the next edge.
    always @(negedge clk) begin
        if (!rst && out_valid === 1'b1 && out_ready === 1'b1) begin
            logic [SEL_W+WIDTH-1:0] exp_w;
            n_tests++;
            assert (exp_q.size() > 0) else begin
                n_fail++;
                $error("FAIL sb_unexpected observed=%0h_%0h expected=none", out_ch, out_data);
            end
            if (exp_q.size() > 0) begin
                exp_w = exp_q.pop_front();
                n_popped++;
                chk("sb_word", {22'd0, out_ch, out_data}, {22'd0, exp_w});
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_bit(input logic [SEL_W-1:0] ch, input logic bit_v, input logic [NUM_CH-1:0] extra);
        logic [NUM_CH-1:0] v;
        v = (bit_v ? ch_onehot(ch) : '0) | extra;
        in_valid = 1'b1;
        sel = ch;
        {d, c, b, a} = v;
        tick();
        in_valid = 1'b0;
        {d, c, b, a} = '0;
    endtask

    task automatic send_word(input logic [SEL_W-1:0] ch, input logic [WIDTH-1:0] w, input bit expect_out);
        for (int i = WIDTH - 1; i >= 0; i--) send_bit(ch, w[i], '0);
        if (expect_out) exp_q.push_back({ch, w});
    endtask

    task automatic chk_idle_outputs(input string tag);
        chk({tag, "_valid"}, {31'd0, out_valid}, 32'd0);
        chk({tag, "_data"}, {24'd0, out_data}, 32'd0);
        chk({tag, "_ch"}, {30'd0, out_ch}, 32'd0);
        chk({tag, "_ovf"}, {31'd0, overflow}, 32'd0);
        chk({tag, "_rerr"}, {31'd0, route_err}, 32'd0);
    endtask

    initial begin
        logic [WIDTH-1:0] w1, w2;
        rst = 1'b1; in_valid = 1'b0; sel = CH_A; {d, c, b, a} = '0;
        out_ready = 1'b1; clr_err = 1'b0;
        tick(); tick();
        chk_idle_outputs("reset");
        rst = 1'b0;

        // 1: 8'hB2 on channel a, one-cycle latency and one-cycle valid
        w1 = 8'hB2;
        for (int i = WIDTH - 1; i >= 1; i--) send_bit(CH_A, w1[i], '0);
        chk("t1_not_yet", {31'd0, out_valid}, 32'd0);
        send_bit(CH_A, w1[0], '0);
        exp_q.push_back({CH_A, w1});
        chk("t1_valid", {31'd0, out_valid}, 32'd1);
        chk("t1_data", {24'd0, out_data}, 32'hB2);
        tick();
        chk("t1_pulse", {31'd0, out_valid}, 32'd0);
        chk("t1_flags", {30'd0, overflow, route_err}, 32'd0);

        // 2: interleaved lanes b and d
        w1 = 8'h5A; w2 = 8'hC3;
        for (int i = WIDTH - 1; i >= 0; i--) begin
            send_bit(CH_B, w1[i], '0);
            if (i == 0) exp_q.push_back({CH_B, w1});
            send_bit(CH_D, w2[i], '0);
            if (i == 0) exp_q.push_back({CH_D, w2});
        end
        tick();
        chk("t2_drained", {31'd0, out_valid}, 32'd0);
        chk("t2_flags", {30'd0, overflow, route_err}, 32'd0);

        // 3: back-pressure, second word dropped
        out_ready = 1'b0;
        send_word(CH_C, 8'hFF, 1'b1);
        chk("t3_full", {31'd0, out_valid}, 32'd1);
        send_word(CH_A, 8'h01, 1'b0);
        chk("t3_hold", {22'd0, out_ch, out_data}, {22'd0, CH_C, 8'hFF});
        chk("t3_ovf", {31'd0, overflow}, 32'd1);
        out_ready = 1'b1;
        tick();
        chk("t3_drain_one", {31'd0, out_valid}, 32'd0);
        clr_err = 1'b1; tick(); clr_err = 1'b0;
        chk("t3_clr", {30'd0, overflow, route_err}, 32'd0);

        // 4: accept and reload in the same cycle
        out_ready = 1'b0;
        send_word(CH_A, 8'h33, 1'b1);
        w1 = 8'h0F;
        for (int i = WIDTH - 1; i >= 1; i--) send_bit(CH_B, w1[i], '0);
        out_ready = 1'b1;
        send_bit(CH_B, w1[0], '0);
        exp_q.push_back({CH_B, w1});
        chk("t4_b2b", {21'd0, out_valid, out_ch, out_data}, {21'd0, 1'b1, CH_B, 8'h0F});
        chk("t4_no_ovf", {31'd0, overflow}, 32'd0);
        tick();
        chk("t4_drained", {31'd0, out_valid}, 32'd0);

        // 5: route fault, clear, clear colliding with a new fault
        send_bit(CH_C, 1'b0, 4'b0001);
        chk("t5_set", {31'd0, route_err}, 32'd1);
        clr_err = 1'b1; tick(); clr_err = 1'b0;
        chk("t5_clr", {31'd0, route_err}, 32'd0);
        clr_err = 1'b1;
        send_bit(CH_C, 1'b1, 4'b1000);
        clr_err = 1'b0;
        chk("t5_set_wins", {31'd0, route_err}, 32'd1);
        chk("t5_no_word", {31'd0, out_valid}, 32'd0);

        // 6: reset mid-word discards the partial word
        w1 = 8'hE7;
        for (int i = WIDTH - 1; i >= 3; i--) send_bit(CH_A, w1[i], '0);
        rst = 1'b1;
        tick();
        chk_idle_outputs("t6_rst");
        rst = 1'b0;
        send_word(CH_A, 8'hA5, 1'b1);
        chk("t6_word", {21'd0, out_valid, out_ch, out_data}, {21'd0, 1'b1, CH_A, 8'hA5});
        tick();

        chk("sb_empty", exp_q.size(), 32'd0);
        chk("sb_count", n_popped, 32'd7);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
